// File: rtl/cpu_mailbox.sv
// cpu_mailbox
//   Byte-stream mailbox between the 65C02 bus and a host-side streaming agent.
//   Two independent circular FIFOs: RX (host -> CPU) and TX (CPU -> host),
//   a 4-register CPU window and a level interrupt.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   en, cs, we, addr, din CPU bus strobe / select / write / register / data
//   dout                  registered read data (updates only on read access)
//   irq                   level interrupt from registered FIFO state
//   tx_data, tx_valid     TX FIFO head to the host, tx_ready from the host
//   rx_data, rx_valid     host byte into RX FIFO, rx_ready back to the host
//
// Register window (access = en && cs)
//   0 DATA    rd: pop RX (0x00 + RX_UNDERRUN if empty)  wr: push TX (drop + TX_OVERRUN if full)
//   1 STATUS  rd: {irq,0,tx_ovr,rx_und,tx_empty,rx_full,tx_not_full,rx_not_empty}
//             wr: 1 in bit 4/5 clears the sticky flag
//   2 CONTROL rd: {6'b0,tx_ie,rx_ie}  wr: [0] rx_ie, [1] tx_ie, [6] rx_flush, [7] tx_flush
//   3 LEVEL   rd: {tx_count[3:0], rx_count[3:0]}
//
// Host handshake: a transfer happens on every clk where valid && ready are
// both high. tx_valid and rx_ready depend only on registered counts (and are
// held low during reset), never on same-cycle CPU activity, so the host may
// treat them as stable for the whole cycle.

module cpu_mailbox #(
  parameter int DEPTH_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  typedef logic [DEPTH_BITS-1:0] ptr_t;
  typedef logic [DEPTH_BITS:0]   cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  // RX FIFO state
  logic [7:0] rx_mem_q [DEPTH];
  logic [7:0] rx_mem_d [DEPTH];
  ptr_t       rx_wr_ptr_q, rx_wr_ptr_d;
  ptr_t       rx_rd_ptr_q, rx_rd_ptr_d;
  cnt_t       rx_count_q,  rx_count_d;

  // TX FIFO state
  logic [7:0] tx_mem_q [DEPTH];
  logic [7:0] tx_mem_d [DEPTH];
  ptr_t       tx_wr_ptr_q, tx_wr_ptr_d;
  ptr_t       tx_rd_ptr_q, tx_rd_ptr_d;
  cnt_t       tx_count_q,  tx_count_d;

  // Control, sticky flags, read data
  logic       rx_ie_q,    rx_ie_d;
  logic       tx_ie_q,    tx_ie_d;
  logic       rx_under_q, rx_under_d;
  logic       tx_over_q,  tx_over_d;
  logic [7:0] dout_q,     dout_d;

  // Decoded events
  logic       rd_acc, wr_acc;
  logic       rx_push, rx_pop, rx_flush;
  logic       tx_push, tx_pop, tx_flush;
  logic       rx_empty, tx_full;
  logic [7:0] status_byte;
  logic [7:0] level_byte;

  assign rx_ready = !reset && (rx_count_q != FULL);
  assign tx_valid = !reset && (tx_count_q != '0);
  assign tx_data  = tx_mem_q[tx_rd_ptr_q];
  assign irq      = (rx_ie_q && (rx_count_q != '0)) || (tx_ie_q && (tx_count_q == '0));
  assign dout     = dout_q;

  assign rx_empty = (rx_count_q == '0);
  assign tx_full  = (tx_count_q == FULL);

  assign rd_acc   = en && cs && !we;
  assign wr_acc   = en && cs &&  we;

  // Fullness/emptiness use only registered counts, so a same-cycle pop on
  // the other side never makes room for a push in that cycle.
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_acc && (addr == 2'd0) && !rx_empty;
  assign tx_push  = wr_acc && (addr == 2'd0) && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_flush = wr_acc && (addr == 2'd2) && din[6];
  assign tx_flush = wr_acc && (addr == 2'd2) && din[7];

  assign status_byte = {irq, 1'b0, tx_over_q, rx_under_q,
                        (tx_count_q == '0), (rx_count_q == FULL),
                        !tx_full, !rx_empty};
  assign level_byte  = {4'(tx_count_q), 4'(rx_count_q)};

  always_comb begin
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
    rx_ie_d     = rx_ie_q;
    tx_ie_d     = tx_ie_q;
    rx_under_d  = rx_under_q;
    tx_over_d   = tx_over_q;
    dout_d      = dout_q;

    // RX FIFO
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = rx_data;
      rx_wr_ptr_d           = rx_wr_ptr_q + ptr_t'(1);
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + ptr_t'(1);
    end
    if (rx_flush) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end

    // TX FIFO
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = din;
      tx_wr_ptr_d           = tx_wr_ptr_q + ptr_t'(1);
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + ptr_t'(1);
    end
    if (tx_flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
    end

    // Read data mux; STATUS reflects state before this cycle's updates.
    if (rd_acc) begin
      case (addr)
        2'd0:    dout_d = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
        2'd1:    dout_d = status_byte;
        2'd2:    dout_d = {6'b0, tx_ie_q, rx_ie_q};
        default: dout_d = level_byte;
      endcase
    end

    if (wr_acc && (addr == 2'd2)) begin
      rx_ie_d = din[0];
      tx_ie_d = din[1];
    end

    // Sticky flags: clears first so that a same-cycle set wins.
    if (wr_acc && (addr == 2'd1)) begin
      if (din[4]) rx_under_d = 1'b0;
      if (din[5]) tx_over_d  = 1'b0;
    end
    if (rd_acc && (addr == 2'd0) && rx_empty) rx_under_d = 1'b1;
    if (wr_acc && (addr == 2'd0) && tx_full)  tx_over_d  = 1'b1;
  end

  // Storage arrays carry no reset; pointers and counts define their contents.
  always_ff @(posedge clk) begin
    rx_mem_q <= rx_mem_d;
    tx_mem_q <= tx_mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      rx_under_q  <= 1'b0;
      tx_over_q   <= 1'b0;
      dout_q      <= 8'h00;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_ie_q     <= rx_ie_d;
      tx_ie_q     <= tx_ie_d;
      rx_under_q  <= rx_under_d;
      tx_over_q   <= tx_over_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: tb/tb_cpu_mailbox.sv
// tb_cpu_mailbox
//   Bench for cpu_mailbox (DEPTH_BITS = 3). A queue-based reference model of
//   the mailbox is updated on every rising edge; a compare process checks
//   dout, irq, tx_valid, tx_data and rx_ready against it on every falling
//   edge. Directed sequences add literal expectations, then a randomized
//   phase exercises arbitrary interleavings.

module tb_cpu_mailbox;

  localparam int DEPTH = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic       en, cs, we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  cpu_mailbox #(.DEPTH_BITS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .irq      (irq),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  // Counters
  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  bit         m_rx_ie, m_tx_ie, m_und, m_ovr;
  logic [7:0] m_dout;
  int         m_rxn, m_txn;
  bit         m_rx_fl, m_tx_fl;
  logic [7:0] m_st;

  function automatic bit model_irq();
    return (m_rx_ie && rx_q.size() != 0) || (m_tx_ie && tx_q.size() == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      rx_q.delete();
      tx_q.delete();
      m_rx_ie = 0; m_tx_ie = 0; m_und = 0; m_ovr = 0;
      m_dout  = 8'h00;
    end else begin
      m_rxn   = rx_q.size();
      m_txn   = tx_q.size();
      m_rx_fl = 0;
      m_tx_fl = 0;
      m_st    = {model_irq(), 1'b0, m_ovr, m_und, m_txn == 0, m_rxn == DEPTH,
                 m_txn != DEPTH, m_rxn != 0};
      if (tx_ready && m_txn > 0) void'(tx_q.pop_front());
      if (en && cs) begin
        if (!we) begin
          case (addr)
            2'd0: if (m_rxn > 0) m_dout = rx_q.pop_front();
                  else begin m_dout = 8'h00; m_und = 1; end
            2'd1: m_dout = m_st;
            2'd2: m_dout = {6'b0, m_tx_ie, m_rx_ie};
            default: m_dout = {4'(m_txn), 4'(m_rxn)};
          endcase
        end else begin
          case (addr)
            2'd0: if (m_txn < DEPTH) tx_q.push_back(din); else m_ovr = 1;
            2'd1: begin
              if (din[4]) m_und = 0;
              if (din[5]) m_ovr = 0;
            end
            2'd2: begin
              m_rx_ie = din[0];
              m_tx_ie = din[1];
              m_rx_fl = din[6];
              m_tx_fl = din[7];
            end
            default: ;
          endcase
        end
      end
      if (rx_valid && m_rxn < DEPTH) rx_q.push_back(rx_data);
      if (m_rx_fl) rx_q.delete();
      if (m_tx_fl) tx_q.delete();
    end
  end

  // Compare process
  bit chk_en = 0;
  logic [7:0] got_q [$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", dout, m_dout);
      chk("irq", {7'b0, irq}, {7'b0, model_irq()});
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, !reset && tx_q.size() != 0});
      chk("rx_ready", {7'b0, rx_ready}, {7'b0, !reset && rx_q.size() < DEPTH});
      if (!reset && tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
    end
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input bit w, input logic [1:0] a, input logic [7:0] d);
    en = 1; cs = 1; we = w; addr = a; din = d;
    tick();
    en = 0; cs = 0; we = 0;
  endtask

  task automatic rd_exp(input logic [1:0] a, input logic [7:0] exp, input string name);
    cpu(0, a, 8'h00);
    chk(name, dout, exp);
  endtask

  task automatic host_push(input logic [7:0] d);
    rx_valid = 1; rx_data = d;
    tick();
    rx_valid = 0;
  endtask

  logic [7:0] exp_seq [$];

  initial begin
    reset = 1; en = 0; cs = 0; we = 0; addr = 0; din = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    tick();
    chk_en = 1;
    tick(); tick();
    reset = 0;

    // Reset state
    rd_exp(2'd1, 8'h0A, "reset_status");
    rd_exp(2'd2, 8'h00, "reset_control");
    rd_exp(2'd3, 8'h00, "reset_level");
    chk("reset_irq", {7'b0, irq}, 8'h00);
    chk("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("reset_rx_ready", {7'b0, rx_ready}, 8'h01);

    // RX fill and drain
    rx_valid = 1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h11 + 8'(i);
      tick();
    end
    rx_valid = 0;
    chk("rx_full_ready", {7'b0, rx_ready}, 8'h00);
    rd_exp(2'd3, 8'h08, "rx_full_level");
    for (int i = 0; i < 8; i++) rd_exp(2'd0, 8'h11 + 8'(i), "rx_drain");
    rd_exp(2'd0, 8'h00, "rx_underrun_data");
    rd_exp(2'd1, 8'h1A, "rx_underrun_status");
    cpu(1, 2'd1, 8'h10);
    rd_exp(2'd1, 8'h0A, "rx_underrun_clear");

    // TX overrun and wrap
    got_q.delete();
    for (int i = 0; i < 9; i++) cpu(1, 2'd0, 8'h20 + 8'(i));
    rd_exp(2'd1, 8'h20, "tx_overrun_status");
    chk("tx_head", tx_data, 8'h20);
    cpu(1, 2'd1, 8'h20);
    tx_ready = 1;
    tick(); tick(); tick();
    tx_ready = 0;
    for (int i = 0; i < 3; i++) cpu(1, 2'd0, 8'h30 + 8'(i));
    tx_ready = 1;
    repeat (12) tick();
    tx_ready = 0;
    exp_seq.delete();
    for (int i = 0; i < 8; i++) exp_seq.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) exp_seq.push_back(8'h30 + 8'(i));
    chk("tx_drain_len", 8'(got_q.size()), 8'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++)
      chk("tx_drain_byte", (i < got_q.size()) ? got_q[i] : 8'hXX, exp_seq[i]);

    // Simultaneous push + pop with 3 bytes held
    for (int i = 0; i < 3; i++) host_push(8'hA0 + 8'(i));
    rx_valid = 1; rx_data = 8'hA3;
    cpu(0, 2'd0, 8'h00);
    rx_valid = 0;
    chk("simul_pop_data", dout, 8'hA0);
    rd_exp(2'd3, 8'h03, "simul_level");
    for (int i = 1; i < 4; i++) rd_exp(2'd0, 8'hA0 + 8'(i), "simul_order");

    // Full RX: CPU pop and host push in the same cycle
    for (int i = 0; i < 8; i++) host_push(8'hB0 + 8'(i));
    rx_valid = 1; rx_data = 8'hB8;
    cpu(0, 2'd0, 8'h00);
    rx_valid = 0;
    chk("full_pop_data", dout, 8'hB0);
    rd_exp(2'd3, 8'h07, "full_refuse_level");
    for (int i = 1; i < 8; i++) rd_exp(2'd0, 8'hB0 + 8'(i), "full_drain");
    rd_exp(2'd3, 8'h00, "full_empty_level");

    // Interrupts and flush
    cpu(1, 2'd2, 8'h03);
    chk("irq_tx_ie", {7'b0, irq}, 8'h01);
    host_push(8'hC0);
    rx_valid = 1; rx_data = 8'hC1;
    cpu(1, 2'd2, 8'h41);
    rx_valid = 0;
    chk("flush_irq", {7'b0, irq}, 8'h00);
    rd_exp(2'd3, 8'h00, "flush_level");
    rd_exp(2'd2, 8'h01, "flush_control");
    cpu(1, 2'd2, 8'h00);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) host_push(8'hD0 + 8'(i));
    rd_exp(2'd0, 8'hD0, "pre_reset_data");
    for (int i = 0; i < 4; i++) cpu(1, 2'd0, 8'hE0 + 8'(i));
    got_q.delete();
    reset = 1; tx_ready = 1;
    tick();
    reset = 0;
    chk("mid_reset_dout", dout, 8'h00);
    chk("mid_reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("mid_reset_pops", 8'(got_q.size()), 8'h00);
    tx_ready = 0;
    rd_exp(2'd3, 8'h00, "mid_reset_level");

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      en       = (c >= 1500 && c < 2000) ? 1'b1 : ($urandom_range(0, 2) == 0);
      cs       = ($urandom_range(0, 3) != 0);
      we       = $urandom_range(0, 1);
      addr     = 2'($urandom_range(0, 3));
      din      = 8'($urandom);
      if (addr == 2'd2 && $urandom_range(0, 7) != 0) din[7:6] = 2'b00;
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) != 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    en = 0; cs = 0; we = 0; rx_valid = 0; tx_ready = 0; reset = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
